// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer for the immediate generator.
// Classifies the opcode, steers instr_i into the external `extend` block,
// forms U-type immediates locally and registers the result toward execute.
// Build option: define IMM_DECODE_SKID_EN to add a skid register and a
// registered instr_ready_o. Without it, the block holds a single output entry.
module imm_decode_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [XLEN-1:0] instr_i,
    output logic [1:0]      ext_imm_src_o,
    output logic [24:0]     ext_instr_o,
    input  logic [XLEN-1:0] ext_imm_i,
    output logic            imm_valid_o,
    input  logic            imm_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o,
    output logic            illegal_o
);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_J    = 3'd4;
    localparam logic [2:0] TYPE_U    = 3'd5;

    logic [2:0]      cls_type;
    logic            new_ill;
    logic [2:0]      new_type;
    logic [XLEN-1:0] new_imm;
    logic            accept;
    logic            retire;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [2:0]      out_type_q,  out_type_d;
    logic            out_ill_q,   out_ill_d;

    assign ext_instr_o = instr_i[31:7];
    assign imm_valid_o = out_valid_q;
    assign imm_o       = out_imm_q;
    assign imm_type_o  = out_type_q;
    assign illegal_o   = out_ill_q;

    // Opcode classification, extend steering and captured entry payload
    always_comb begin
        cls_type      = TYPE_NONE;
        ext_imm_src_o = 2'b00;
        case (instr_i[6:0])
            7'b0000011, 7'b0000111, 7'b0010011,
            7'b1100111, 7'b1110011: begin
                cls_type      = TYPE_I;
                ext_imm_src_o = 2'b00;
            end
            7'b0100011, 7'b0100111: begin
                cls_type      = TYPE_S;
                ext_imm_src_o = 2'b01;
            end
            7'b1100011: begin
                cls_type      = TYPE_B;
                ext_imm_src_o = 2'b10;
            end
            7'b1101111: begin
                cls_type      = TYPE_J;
                ext_imm_src_o = 2'b11;
            end
            7'b0110111, 7'b0010111: begin
                cls_type      = TYPE_U;
                ext_imm_src_o = 2'b00;
            end
            default: begin
                cls_type      = TYPE_NONE;
                ext_imm_src_o = 2'b00;
            end
        endcase

        new_ill  = (instr_i[1:0] != 2'b11);
        new_type = new_ill ? TYPE_NONE : cls_type;

        case (new_type)
            TYPE_I, TYPE_S, TYPE_B, TYPE_J: new_imm = ext_imm_i;
            TYPE_U:                         new_imm = {instr_i[31:12], 12'b0};
            default:                        new_imm = '0;
        endcase
    end

    assign retire = out_valid_q && imm_ready_i;
    assign accept = instr_valid_i && instr_ready_o;

`ifdef IMM_DECODE_SKID_EN

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic [2:0]      skid_type_q,  skid_type_d;
    logic            skid_ill_q,   skid_ill_d;
    logic            ready_q,      ready_d;

    assign instr_ready_o = ready_q;

    // Next-state for output and skid registers; ready tracks "skid empty"
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_ill_d   = skid_ill_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (retire && skid_valid_q) begin
            // Skid full means ready was low, so no accept this cycle
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_type_d   = skid_type_q;
            out_ill_d    = skid_ill_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!out_valid_q || retire)) begin
            out_valid_d = 1'b1;
            out_imm_d   = new_imm;
            out_type_d  = new_type;
            out_ill_d   = new_ill;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = new_imm;
            skid_type_d  = new_type;
            skid_ill_d   = new_ill;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end

        ready_d = !skid_valid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= TYPE_NONE;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= TYPE_NONE;
            skid_ill_q   <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_ill_q   <= skid_ill_d;
            ready_q      <= ready_d;
        end
    end

`else

    assign instr_ready_o = !out_valid_q || imm_ready_i;

    // Next-state for the single output register
    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_type_d  = out_type_q;
        out_ill_d   = out_ill_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = new_imm;
            out_type_d  = new_type;
            out_ill_d   = new_ill;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_type_q  <= TYPE_NONE;
            out_ill_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_type_q  <= out_type_d;
            out_ill_q   <= out_ill_d;
        end
    end

`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed steps then random traffic
// against a queue-based reference model. Includes a stand-in for `extend`.
module tb_imm_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [1:0]  ext_imm_src;
    logic [24:0] ext_instr;
    logic [31:0] ext_imm;
    logic        imm_valid;
    logic        imm_ready;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        illegal;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    imm_decode_ctrl #(.XLEN(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .ext_imm_src_o (ext_imm_src),
        .ext_instr_o   (ext_instr),
        .ext_imm_i     (ext_imm),
        .imm_valid_o   (imm_valid),
        .imm_ready_i   (imm_ready),
        .imm_o         (imm),
        .imm_type_o    (imm_type),
        .illegal_o     (illegal)
    );

    // RISC-V immediate formats by kind: 1 I, 2 S, 3 B, 4 J, 5 U
    function automatic logic [31:0] fmt_imm(input int kind, input logic [31:0] i);
        case (kind)
            1: return {{20{i[31]}}, i[31:20]};
            2: return {{20{i[31]}}, i[31:25], i[11:7]};
            3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            5: return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Stand-in for the external extend block
    always_comb begin
        ext_imm = fmt_imm(int'(ext_imm_src) + 1, {ext_instr, 7'b0});
    end

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'h03, 7'h07, 7'h13, 7'h67, 7'h73: return 1;
            7'h23, 7'h27:                      return 2;
            7'h63:                             return 3;
            7'h6F:                             return 4;
            7'h37, 7'h17:                      return 5;
            default:                           return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_src(input logic [31:0] i);
        int k = kind_of(i[6:0]);
        if (k >= 1 && k <= 4) return 2'(k - 1);
        return 2'b00;
    endfunction

    function automatic ent_t model(input logic [31:0] i);
        ent_t e;
        int k = kind_of(i[6:0]);
        e.ill = (i[1:0] != 2'b11);
        if (e.ill) k = 0;
        e.typ = 3'(k);
        e.imm = fmt_imm(k, i);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against model, clock, advance model
    task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy,
                       input logic fl, input logic rst);
        logic exp_ready;
        logic acc;
        logic ret;
        instr_valid = v;
        instr       = ins;
        imm_ready   = rdy;
        flush       = fl;
        rst_n       = ~rst;
        #1;
`ifdef IMM_DECODE_SKID_EN
        exp_ready = (q.size() < 2);
`else
        exp_ready = (q.size() == 0) || rdy;
`endif
        if (chk_en) begin
            chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
            chk("imm_valid", 32'(imm_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("imm", imm, q[0].imm);
                chk("imm_type", 32'(imm_type), 32'(q[0].typ));
                chk("illegal", 32'(illegal), 32'(q[0].ill));
            end
            chk("ext_imm_src", 32'(ext_imm_src), 32'(exp_src(ins)));
            chk("ext_instr", 32'(ext_instr), 32'(ins[31:7]));
        end
        acc = v && exp_ready;
        ret = (q.size() != 0) && rdy;
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(model(ins));
        end
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_imm,
                           input logic [2:0] e_typ, input logic e_ill);
        chk({tag, "_valid"}, 32'(imm_valid), 32'd1);
        chk({tag, "_imm"}, imm, e_imm);
        chk({tag, "_type"}, 32'(imm_type), 32'(e_typ));
        chk({tag, "_ill"}, 32'(illegal), 32'(e_ill));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(imm_valid), 32'd0);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_type"}, 32'(imm_type), 32'd0);
        chk({tag, "_ill"}, 32'(illegal), 32'd0);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14] = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h73, 7'h23, 7'h27,
                                 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F, 7'h5B};
        logic [31:0] i = $urandom;
        i[6:0] = ops[$urandom_range(0, 13)];
        if ($urandom_range(0, 7) == 0) i[1:0] = 2'($urandom_range(0, 2));
        return i;
    endfunction

    initial begin
        instr_valid = 1'b0;
        instr       = 32'h0;
        imm_ready   = 1'b0;
        flush       = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        cyc(0, 32'h0, 0, 0, 1);
        cyc(0, 32'h0, 0, 0, 1);
        chk_en = 1;
        chk_reset_state("reset");

        // Basic decode of each type
        cyc(1, 32'hFFF00093, 1, 0, 0);
        chk_out("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc(1, 32'hFE112E23, 1, 0, 0);
        chk_out("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
        cyc(1, 32'h0080006F, 1, 0, 0);
        chk_out("jal", 32'h00000008, 3'd4, 1'b0);
        cyc(1, 32'h123450B7, 1, 0, 0);
        chk_out("lui", 32'h12345000, 3'd5, 1'b0);
        cyc(1, 32'h00000033, 1, 0, 0);
        chk_out("add", 32'h0, 3'd0, 1'b0);
        cyc(1, 32'h00000000, 1, 0, 0);
        chk_out("zero", 32'h0, 3'd0, 1'b1);
        cyc(0, 32'h0, 1, 0, 0);

        // Backpressure: stream three with downstream stalled, then drain
        cyc(1, 32'h00100093, 0, 0, 0);
        cyc(1, 32'h00200113, 0, 0, 0);
        cyc(1, 32'h00300193, 0, 0, 0);
        cyc(1, 32'h00300193, 0, 0, 0);
`ifdef IMM_DECODE_SKID_EN
        chk("bp_full_ready", 32'(instr_ready), 32'd0);
`endif
        chk_out("bp_hold", 32'h1, 3'd1, 1'b0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // Flush with buffered entries and a valid input
        cyc(1, 32'h00400093, 0, 0, 0);
        cyc(1, 32'h00500093, 0, 0, 0);
        cyc(1, 32'h00600093, 0, 1, 0);
        chk("flush_valid", 32'(imm_valid), 32'd0);
        chk("flush_ready", 32'(instr_ready), 32'd1);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // Reset with buffer full
        cyc(1, 32'h00700093, 0, 0, 0);
        cyc(1, 32'h00800093, 0, 0, 0);
        cyc(1, 32'h00900093, 0, 0, 1);
        chk_reset_state("midreset");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic v;
            logic rdy;
            v   = ($urandom_range(0, 3) != 0);
            rdy = (n % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(v, rand_instr(), rdy, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage sequencer for the immediate generator (`extend`). It accepts fetched instructions over a valid/ready handshake and classifies the opcode to drive `imm_src` and `instr[31:7]` into `extend`. It also forms U-type immediates locally, because `extend` has no U encoding. The result is registered, together with type and illegal flags, toward the execute stage, with backpressure and flush support.

## Interface
Parameters:
- XLEN, 32: data width; only 32 is supported.

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  discard all buffered entries and any input accepted this cycle.
- instr_valid_i  in  1  upstream instruction valid.
- instr_ready_o  out  1  block can accept an instruction.
- instr_i  in  32  instruction word.
- ext_imm_src_o  out  2  combinational `imm_src`, derived from `instr_i`, driven to `extend`.
- ext_instr_o  out  25  combinational `instr_i[31:7]`, driven to `extend`.
- ext_imm_i  in  32  extended immediate returned combinationally from `extend`.
- imm_valid_o  out  1  output entry valid.
- imm_ready_i  in  1  downstream accepts the entry.
- imm_o  out  32  registered immediate.
- imm_type_o  out  3  registered type: 0 none, 1 I, 2 S, 3 B, 4 J, 5 U.
- illegal_o  out  1  registered flag: `instr_i[1:0]` != 2'b11.

## Operation
- Opcode classification on `instr_i[6:0]`:
  - I: 0000011, 0000111, 0010011, 1100111, 1110011
  - S: 0100011, 0100111
  - B: 1100011
  - J: 1101111
  - U: 0110111, 0010111
  - Any other opcode is type none.
- `ext_imm_src_o` encoding: I=00, S=01, B=10, J=11. For U and none it drives 00, and the result is ignored.
- Captured immediate value:
  - I/S/B/J: `ext_imm_i`.
  - U: {`instr_i[31:12]`, 12'b0}.
  - none or illegal: 32'h0.
- If illegal, `imm_type_o` = 0 regardless of opcode.
- A transfer occurs when `instr_valid_i && instr_ready_o`. The entry is written into the output register, or into the skid register when the output register is held.
- The output entry retires when `imm_valid_o && imm_ready_i`. If the skid register holds an entry, that entry moves to the output register on the same edge.
- Ordering is strict FIFO; entries are never reordered or dropped except by flush or reset.

## Timing
- Reset (`rst_ni` = 0 at an edge): `imm_valid_o`=0, `imm_o`=0, `imm_type_o`=0, `illegal_o`=0, skid register empty, `instr_ready_o`=1 in the following cycle.
- Reset mid-operation discards all entries. Reset has priority over flush and over any handshake.
- Latency: an instruction accepted at edge N appears on `imm_valid_o` after edge N. This is 1 cycle when the output register is empty or retiring.
- `instr_ready_o` is a registered signal equal to "skid register empty". It has no combinational path from `imm_ready_i`.
- Full buffer (output and skid both occupied): `instr_ready_o`=0. It rises the cycle after a retirement.
- Simultaneous accept and retire with only the output register occupied: the new entry goes straight to the output register; the skid register stays empty.
- `flush_i`=1 at an edge: both entries are invalidated, any same-cycle input is dropped, and `instr_ready_o`=1 next cycle. Flush beats `imm_ready_i`.
- While `imm_valid_o`=1 and `imm_ready_i`=0, `imm_o`, `imm_type_o` and `illegal_o` must remain stable.

## Configuration
- `IMM_DECODE_SKID_EN` defined: the 2-entry skid buffer is present, as described above, with a registered `instr_ready_o`.
- Not defined: the skid register is removed. `instr_ready_o` = `!imm_valid_o || imm_ready_i` (combinational). Latency, flush and reset behaviour are unchanged.

## Test plan
- Reset, then `instr_i`=0xFFF00093 (addi) with valid -> next cycle `imm_valid_o`=1, `imm_o`=0xFFFFFFFF, `imm_type_o`=1, `ext_imm_src_o`=00 during the input cycle.
- `instr_i`=0xFE112E23 (sw) -> `imm_o`=0xFFFFFFFC, type 2. Then `instr_i`=0x0080006F (jal) -> `imm_o`=0x00000008, type 4.
- `instr_i`=0x123450B7 (lui) -> `imm_o`=0x12345000, type 5. Then `instr_i`=0x00000033 (add) -> `imm_o`=0, type 0. Then `instr_i`=0x00000000 -> `illegal_o`=1, type 0.
- Hold `imm_ready_i`=0 and stream 3 instructions -> 2 are accepted, `instr_ready_o`=0, and output stays stable. Release ready -> entries retire in order, 1 per cycle.
- Assert `flush_i` with 2 entries buffered and a valid input -> next cycle `imm_valid_o`=0 and `instr_ready_o`=1; none of the three entries ever appear.
- Drive `rst_ni`=0 for one edge with the buffer full -> all outputs 0 and ready=1. Repeat the backpressure test with `IMM_DECODE_SKID_EN` undefined -> ready follows `imm_ready_i` combinationally.
